// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer and its digit-pair counters.
// The packed-BCD pair format matches the up-counting clock, so one display path serves both.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_pair_t;

  localparam bcd_pair_t BCD_59   = 8'h59;
  localparam bcd_pair_t BCD_ZERO = 8'h00;

  // True when the units digit is 0..9 and the tens digit does not exceed max_tens.
  function automatic logic bcd_pair_ok(bcd_pair_t v, bcd_digit_t max_tens);
    return (v[7:4] <= max_tens) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_pair_down.sv
// One packed-BCD digit pair that counts down, wrapping 00 -> MOD_MAX and raising a borrow.
// Used for seconds and minutes (MOD_MAX 59) and for hours (MOD_MAX 99, never wraps in use).
module bcd_pair_down
  import bcd_countdown_timer_pkg::*;
#(
  parameter int MOD_MAX = 59
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  bcd_pair_t load_value,
  input  logic      dec_en,
  output bcd_pair_t value,
  output logic      borrow_out,
  output logic      zero
);

  localparam bcd_digit_t WRAP_TENS  = bcd_digit_t'(MOD_MAX / 10);
  localparam bcd_digit_t WRAP_UNITS = bcd_digit_t'(MOD_MAX % 10);

  bcd_pair_t value_reg;
  bcd_pair_t value_next;

  always_comb begin
    value_next = value_reg;
    if (load) begin
      value_next = load_value;
    end else if (dec_en) begin
      if (value_reg == BCD_ZERO) begin
        value_next = {WRAP_TENS, WRAP_UNITS};
      end else if (value_reg[3:0] == 4'd0) begin
        value_next = {value_reg[7:4] - 4'd1, 4'd9};
      end else begin
        value_next = {value_reg[7:4], value_reg[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= BCD_ZERO;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value      = value_reg;
  assign zero       = (value_reg == BCD_ZERO);
  assign borrow_out = dec_en && !load && (value_reg == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// hh:mm:ss BCD countdown timer: preset validation, run/pause FSM and 1 s prescaler.
// Decrements once per tick through a sec -> min -> hour borrow chain and stops at zero.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int CLK_DIV  = 100000000,
  parameter int MAX_HOUR = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       load,
  input  logic [7:0] load_hour,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  state_t        state_reg;
  state_t        state_next;
  logic [PW-1:0] presc_reg;
  logic          running_reg;
  logic          done_reg;
  logic          expired_reg;
  logic          load_err_reg;

  logic [6:0] hour_dec;
  logic       preset_ok;
  logic       load_ok;
  logic       load_bad;
  logic       advance;
  logic       tick;
  logic       reaching_zero;
  logic       count_zero;

  bcd_pair_t sec_value, min_value, hour_value;
  logic      sec_borrow, min_borrow, hour_borrow;
  logic      sec_zero, min_zero, hour_zero;

  assign hour_dec  = {3'b000, load_hour[7:4]} * 7'd10 + {3'b000, load_hour[3:0]};
  assign preset_ok = bcd_pair_ok(load_hour, 4'd9) && (hour_dec <= 7'(MAX_HOUR)) &&
                     bcd_pair_ok(load_min, 4'd5) && bcd_pair_ok(load_sec, 4'd5);
  assign load_ok   = load && preset_ok;
  assign load_bad  = load && !preset_ok;

  // Any load (even a rejected one) and pause outrank the tick, freezing the prescaler.
  assign advance       = (state_reg == RUN) && enable && !load && !pause;
  assign tick          = advance && (presc_reg == PRESC_LAST);
  assign count_zero    = hour_zero && min_zero && sec_zero;
  assign reaching_zero = tick && hour_zero && min_zero && (sec_value == 8'h01);

  bcd_pair_down #(.MOD_MAX(59)) u_sec (
    .clk(clk), .rst(rst), .load(load_ok), .load_value(load_sec),
    .dec_en(tick), .value(sec_value), .borrow_out(sec_borrow), .zero(sec_zero)
  );

  bcd_pair_down #(.MOD_MAX(59)) u_min (
    .clk(clk), .rst(rst), .load(load_ok), .load_value(load_min),
    .dec_en(sec_borrow), .value(min_value), .borrow_out(min_borrow), .zero(min_zero)
  );

  bcd_pair_down #(.MOD_MAX(99)) u_hour (
    .clk(clk), .rst(rst), .load(load_ok), .load_value(load_hour),
    .dec_en(min_borrow), .value(hour_value), .borrow_out(hour_borrow), .zero(hour_zero)
  );

  always_comb begin
    state_next = state_reg;
    if (load_ok) begin
      state_next = IDLE;
    end else if (!load) begin
      if (pause) begin
        if (state_reg == RUN) state_next = PAUSE;
      end else if (start && (((state_reg == IDLE) && !count_zero) || (state_reg == PAUSE))) begin
        state_next = RUN;
      end else if (reaching_zero || hour_borrow) begin
        // hour_borrow would mean a tick at zero; treat it as expiry rather than wrapping.
        state_next = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      presc_reg    <= '0;
      running_reg  <= 1'b0;
      done_reg     <= 1'b0;
      expired_reg  <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load_ok) begin
        presc_reg <= '0;
      end else if (advance) begin
        presc_reg <= tick ? '0 : presc_reg + 1'b1;
      end
      running_reg  <= (state_next == RUN);
      done_reg     <= (state_next == DONE) && (state_reg == RUN);
      expired_reg  <= (state_next == DONE);
      load_err_reg <= load_bad;
    end
  end

  assign hour     = hour_value;
  assign min      = min_value;
  assign sec      = sec_value;
  assign running  = running_reg;
  assign done     = done_reg;
  assign expired  = expired_reg;
  assign load_err = load_err_reg;

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Countdown counterpart to the up-counting digital clock. Loads an hh:mm:ss BCD preset and decrements once per prescaled tick to 00:00:00, then raises an expiry flag. Uses the clock's 8-bit packed-BCD sec/min/hour format, so the same display path can show either block.

Parameters:
CLK_DIV, 100000000, clk cycles per 1 s tick (≥2; bench uses 4)
MAX_HOUR, 23, largest legal hour preset (BCD-checked)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  tick gate; low freezes prescaler and time, commands still honoured
load  in  1  capture load_hour/min/sec this cycle
load_hour  in  8  BCD hours preset, 00..MAX_HOUR
load_min  in  8  BCD minutes preset, 00..59
load_sec  in  8  BCD seconds preset, 00..59
start  in  1  begin/resume countdown
pause  in  1  suspend countdown
hour  out  8  BCD remaining hours
min  out  8  BCD remaining minutes
sec  out  8  BCD remaining seconds
running  out  1  high in RUN
done  out  1  one-cycle pulse on reaching zero
expired  out  1  level, high in DONE
load_err  out  1  one-cycle pulse, rejected preset

Behaviour:
- Reset: hour/min/sec=00, running=done=expired=load_err=0, prescaler=0, state IDLE. Reset mid-run takes effect on the next edge.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Command priority per cycle: rst > load > pause > start > tick.
- load, any state:
  - Valid preset (every nibble ≤9, tens of min/sec ≤5, hour ≤MAX_HOUR): capture the value, go to IDLE, clear prescaler, expired=0.
  - Invalid preset: load_err=1 for one cycle; value, state and prescaler unchanged.
- start:
  - IDLE with nonzero value → RUN. IDLE with value 000000 → ignored.
  - PAUSE → RUN.
  - RUN and DONE → ignored. Leaving DONE requires load.
- pause: RUN → PAUSE; ignored in other states. start and pause in the same cycle: pause wins.
- Prescaler:
  - Counts 0..CLK_DIV-1 only when state RUN and enable=1.
  - Holds its count in PAUSE and while enable=0, so the partial second is kept.
  - Tick when it equals CLK_DIV-1 and advances; it then wraps to 0.
  - First tick occurs CLK_DIV cycles after the start edge, from prescaler 0.
- Decrement on tick, BCD borrow chain:
  - sec units 0 → 9 with borrow; sec 00 → 59 and borrow into min.
  - min 00 → 59 and borrow into hour; hour decrements with BCD units wrap 0→9.
  - Hour never wraps because the count stops at zero.
- Zero detect: the tick that produces 00:00:00 also moves the state to DONE in the same edge. done=1 for exactly that cycle, expired=1, running=0.
- DONE holds zero until load or rst.
- load while RUN or PAUSE aborts the countdown (state IDLE, running=0).

Decomposition:
- Shared package: state enum {IDLE,RUN,PAUSE,DONE}, 4-bit BCD digit typedef, 8-bit BCD pair typedef, constants BCD_59=8'h59, BCD_ZERO=8'h00.
- One sub-module, bcd_pair_down: 8-bit BCD register with load, dec_en, borrow_out, zero flag, and parameter MOD_MAX (59 or 99). Instantiated for sec, min and hour.
- Top level holds the FSM, prescaler and preset validation.

Test Plan (CLK_DIV=4):
1. Load 00:01:00, start → sec/min read 00:00:59 4 cycles after start, 00:00:58 after 8; running=1 throughout.
2. Load 00:00:02, start → 00:00:00 at cycle 8 with done=1 for one cycle, expired=1, running=0; later start keeps DONE and zero.
3. Load 01:00:00, start → after first tick 00:59:59; a further 4 cycles gives 00:59:58.
4. Load 00:60:00, then 24:00:00, then 00:0A:00 → load_err pulses each time; outputs and state unchanged from the prior valid value.
5. Load 00:00:05, start, pause 2 cycles in, hold 10 cycles, and also hold enable=0 for 5 cycles while running → values frozen in both holds. After resume (start, enable=1), the next tick arrives after 2 more counting cycles.
6. In RUN, assert load=1 (00:00:09) together with start, then separately assert rst → load wins (IDLE, 00:00:09, running=0); rst gives all outputs 0 and IDLE on the next edge.
